lcd1602_reader: RTL
===================

Name: lcd1602_reader

Overview:
HD44780/LCD1602 bus read engine: the read-side counterpart of the existing LCD write sequencer on the same 8-bit LCD bus.
- Executes single read transactions: busy-flag/address-counter read (RS=0, RW=1) and DDRAM/CGRAM data read (RS=1, RW=1).
- Optional busy polling until BF=0, bounded by a timeout.
- Shares LCD_RS/LCD_RW/LCD_EN/LCD_DATA with the writer through an external mux. Releases the data bus via lcd_data_oe.
- Timing is in iclk cycles at clk_mhz = 27.

Parameters:
- clk_mhz, 27, iclk frequency in MHz (documentation; cycle counts below are sized for 27 MHz).
- T_AS, 2, address setup cycles: RS/RW valid before EN rises (≥60 ns).
- T_EN, 13, EN high cycles (≥450 ns); data sampled on the last EN-high cycle (≥360 ns after rise).
- T_H, 2, hold cycles after EN falls with RS/RW held.
- T_GAP, 10, recovery cycles with RW=0 before the next EN pulse or done.
- POLL_MAX, 1000, maximum busy-poll reads before timeout; ≥1.

Ports:
- iclk  in  1  system clock, 27 MHz.
- irst  in  1  asynchronous active-low reset.
- req  in  1  start request; sampled only in IDLE.
- req_rs  in  1  0 = busy-flag/address read, 1 = data read.
- poll_busy  in  1  with req_rs=0: repeat read until BF=0.
- lcd_data_in  in  8  LCD_DATA input side from the tristate buffer.
- rdata  out  8  last captured byte; for RS=0, bit 7 = BF and bits 6:0 = AC.
- rdata_valid  out  1  one-cycle pulse when the result is ready.
- timeout  out  1  valid with rdata_valid; poll ended with BF still 1.
- busy  out  1  high from request acceptance until the rdata_valid cycle inclusive.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  1 = read.
- LCD_EN  out  1  enable strobe.
- lcd_data_oe  out  1  1 = FPGA drives LCD_DATA, 0 = released to LCD.

Behaviour:
- Reset (async, irst=0) sets:
  - LCD_EN=0, LCD_RW=0, LCD_RS=0, lcd_data_oe=1.
  - rdata=8'h00, rdata_valid=0, timeout=0, busy=0.
  - Poll counter 0; state IDLE.
  - Applies mid-transaction as well: EN drops immediately and no rdata_valid is issued.
- States: IDLE, SETUP, EN_HI, HOLD, GAP, DONE. One down-counter is reloaded on every state entry.
- IDLE:
  - req=1 at edge k: latch req_rs and poll_busy, clear the poll counter, go to SETUP.
  - busy=1 from cycle k+1.
- SETUP, T_AS cycles:
  - LCD_RS=latched rs, LCD_RW=1, lcd_data_oe=0, LCD_EN=0.
- EN_HI, T_EN cycles:
  - LCD_EN=1.
  - At the edge ending the last EN_HI cycle: rdata<=lcd_data_in.
- HOLD, T_H cycles:
  - LCD_EN=0; RS, RW and oe unchanged.
- GAP, T_GAP cycles:
  - LCD_RW=0, oe stays 0.
  - On exit:
    - If polling and rdata[7]=1 and poll count+1 < POLL_MAX: increment the counter and go to SETUP.
    - If polling and rdata[7]=1 and poll count+1 = POLL_MAX: set timeout=1 and go to DONE.
    - Otherwise go to DONE.
- DONE, 1 cycle:
  - rdata_valid=1, busy=1, oe=1, RW=0, RS=0.
  - Next cycle IDLE, busy=0; timeout returns to 0.
- Latency with default parameters, req at edge k:
  - EN high in cycles k+3..k+15.
  - rdata_valid in cycle k+28.
  - Each extra poll adds 27 cycles.
- Ordering rules:
  - LCD_RW never rises while lcd_data_oe=1.
  - lcd_data_oe never rises while LCD_RW=1.
  - RS/RW are stable throughout every EN-high interval.
- Requests while busy=1 are ignored and not queued. A req held high in DONE is not accepted until IDLE.
- A data read with poll_busy=1 ignores polling: exactly one EN pulse.
- rdata holds its value until the next capture.

Test Plan:
- Data read, lcd_data_in=8'h41, req_rs=1 pulse at k:
  - RS=1, RW=1, EN high for exactly 13 cycles starting k+3.
  - rdata_valid at k+28 with rdata=8'h41; busy low at k+29.
- Busy read without poll, lcd_data_in=8'h85:
  - One EN pulse, RS=0, rdata=8'h85, timeout=0.
- Poll, BF=1 for the first 3 reads then lcd_data_in=8'h07:
  - 4 EN pulses spaced 27 cycles apart.
  - rdata=8'h07, timeout=0, rdata_valid at k+28+3·27.
- Poll with BF stuck at 1 and POLL_MAX=4:
  - Exactly 4 EN pulses, then rdata_valid with timeout=1 and rdata[7]=1.
- Assert irst=0 mid-EN_HI:
  - LCD_EN, LCD_RW=0 and lcd_data_oe=1 immediately; no rdata_valid.
  - After release, a new req completes normally.
- Second req pulsed at k+5 during an active read:
  - Ignored: only one EN pulse, one rdata_valid.
  - A bus checker asserts no RW rise while oe=1 throughout.

Source files
------------

// File: rtl/lcd1602_reader.sv
// lcd1602_reader: HD44780 read engine (busy-flag/AC or data read, optional busy polling with timeout)
module lcd1602_reader #(
  parameter int clk_mhz  = 27,
  parameter int T_AS     = (60 * clk_mhz + 999) / 1000,
  parameter int T_EN     = (450 * clk_mhz + 999) / 1000,
  parameter int T_H      = 2,
  parameter int T_GAP    = 10,
  parameter int POLL_MAX = 1000
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       req,
  input  logic       req_rs,
  input  logic       poll_busy,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       timeout,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       lcd_data_oe
);
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, GAP, DONE} state_t;

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_load;
  logic [PW-1:0] poll_cnt;
  logic          rs_q, poll_q, last, more, at_limit;

  assign last     = cnt == 8'd0;
  assign more     = poll_q && rdata[7];
  assign at_limit = int'(poll_cnt) + 1 >= POLL_MAX;

  // state register; the phase counter reloads whenever a new state is entered
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? cnt_load : cnt - 1'b1;
    end
  end

  // next-state logic and per-state counter reload value
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? SETUP : IDLE;
      SETUP:   state_n = last ? EN_HI : SETUP;
      EN_HI:   state_n = last ? HOLD : EN_HI;
      HOLD:    state_n = last ? GAP : HOLD;
      GAP:     state_n = last ? ((more && !at_limit) ? SETUP : DONE) : GAP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_load = state_n == SETUP ? 8'(T_AS - 1)  :
               state_n == EN_HI ? 8'(T_EN - 1)  :
               state_n == HOLD  ? 8'(T_H - 1)   :
               state_n == GAP   ? 8'(T_GAP - 1) : 8'd0;
  end

  // request latching, poll counting, byte capture at the end of EN and timeout flag for DONE
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      poll_cnt <= '0;
      rdata    <= 8'h00;
      timeout  <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        rs_q     <= req_rs;
        poll_q   <= poll_busy && !req_rs;
        poll_cnt <= '0;
      end
      if (state == GAP && last && more && !at_limit) poll_cnt <= poll_cnt + 1'b1;
      if (state == EN_HI && last) rdata <= lcd_data_in;
      timeout <= state == GAP && last && more && at_limit;
    end
  end

  // bus and status outputs decoded from state; RW drops in GAP before oe returns in DONE
  always_comb begin
    busy        = state != IDLE;
    rdata_valid = state == DONE;
    LCD_EN      = state == EN_HI;
    LCD_RW      = state == SETUP || state == EN_HI || state == HOLD;
    LCD_RS      = rs_q && (LCD_RW || state == GAP);
    lcd_data_oe = state == IDLE || state == DONE;
  end
endmodule
